// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and constants for the four-way round-robin arbiter
//
// Purpose: FSM state encoding, requester count, default hold limit and a
//          one-hot helper used by arbitro_rr4.
// Ports:   none (package).

package arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_e;

  localparam int N_REQ            = 4;
  localparam int HOLD_MAX_DEFAULT = 8;

  function automatic logic [N_REQ-1:0] onehot4(input logic [1:0] idx);
    onehot4      = '0;
    onehot4[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational first-request picker in rotating order
//
// Purpose: returns the first request, searching start, start+1, start+2,
//          start+3 (mod 4), that is not masked by excl.
// Ports:   req   in  [3:0] request vector
//          start in  [1:0] first index searched
//          excl  in  [3:0] requesters that may not be picked
//          found out       a candidate exists
//          idx   out [1:0] index of that candidate (start when none)

module rr_pick4
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [1:0]       start,
  input  logic [N_REQ-1:0] excl,
  output logic             found,
  output logic [1:0]       idx
);

  logic [1:0] cand;

  // Walk from the farthest offset back to the nearest so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    idx   = start;
    cand  = start;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = start + 2'(k);
      if (req[cand] && !excl[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/arbitro_rr4.sv
// rtl/arbitro_rr4.sv - four-way round-robin arbiter driving a 4:1 mux select
//
// Purpose: grants one of four requesters at a time, rotates priority after
//          each release or timeout, and limits consecutive ownership to
//          HOLD_MAX cycles while another requester waits.
// Ports:   clk     in       rising-edge clock
//          reset_n in       asynchronous active-low reset
//          req     in  [3:0] request vector
//          gnt     out [3:0] registered one-hot grant (or zero)
//          sel     out [1:0] registered grantee index, drives mux S
//          busy    out       registered, high while any grant is active

module arbitro_rr4
  import arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = HOLD_MAX_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [1:0]       sel,
  output logic             busy
);

  localparam logic [7:0] HOLD_CNT = 8'(HOLD_MAX);

  state_e           state_q;
  logic [1:0]       ptr_q;
  logic [1:0]       sel_q;
  logic [7:0]       cnt_q;
  logic [N_REQ-1:0] gnt_q;
  logic             busy_q;

  logic [1:0]       pick_start;
  logic [N_REQ-1:0] pick_excl;
  logic             pick_found;
  logic [1:0]       pick_idx;
  logic             own_req;
  logic             others_req;

  // While owning, the search starts after the owner and never returns it, so
  // a requester that releases cannot immediately win again.
  always_comb begin
    pick_start = ptr_q;
    pick_excl  = '0;
    if (state_q == ST_OWN) begin
      pick_start = sel_q + 2'd1;
      pick_excl  = gnt_q;
    end
    own_req    = |(req & gnt_q);
    others_req = |(req & ~gnt_q);
  end

  rr_pick4 u_pick (
    .req   (req),
    .start (pick_start),
    .excl  (pick_excl),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= 2'd0;
      sel_q   <= 2'd0;
      cnt_q   <= 8'd0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // sel keeps its last value while idle
          if (pick_found) begin
            state_q <= ST_OWN;
            gnt_q   <= onehot4(pick_idx);
            sel_q   <= pick_idx;
            busy_q  <= 1'b1;
            cnt_q   <= 8'd1;
          end
        end
        ST_OWN: begin
          if (!own_req) begin
            // release: hand over without an idle bubble when possible
            ptr_q <= sel_q + 2'd1;
            if (pick_found) begin
              gnt_q <= onehot4(pick_idx);
              sel_q <= pick_idx;
              cnt_q <= 8'd1;
            end else begin
              state_q <= ST_IDLE;
              gnt_q   <= '0;
              busy_q  <= 1'b0;
              cnt_q   <= 8'd0;
            end
          end else if (others_req && (cnt_q >= HOLD_CNT)) begin
            // timeout: others_req guarantees pick_found here
            ptr_q <= sel_q + 2'd1;
            gnt_q <= onehot4(pick_idx);
            sel_q <= pick_idx;
            cnt_q <= 8'd1;
          end else if (cnt_q < HOLD_CNT) begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_arbitro_rr4.sv
// tb/tb_arbitro_rr4.sv - self-checking bench for arbitro_rr4

module tb_arbitro_rr4;

  localparam int H = 2;

  logic       clk;
  logic       reset_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;

  logic [3:0] mux_data;
  logic       mux_out;

  int n_checks;
  int n_errors;

  // reference model state
  int m_owner;   // -1 when idle
  int m_ptr;
  int m_cnt;
  int m_sel;

  arbitro_rr4 #(.HOLD_MAX(H)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // sources a..d feed the mux; sel drives S
  assign mux_out = mux_data[sel];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int first_from(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (start + k) % 4;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_cnt   = 0;
    m_sel   = 0;
  endtask

  task automatic model_step(input logic [3:0] r);
    int o;
    int w;
    logic [3:0] others;
    if (m_owner < 0) begin
      w = first_from(r, m_ptr);
      if (w >= 0) begin
        m_owner = w;
        m_sel   = w;
        m_cnt   = 1;
      end
    end else begin
      o         = m_owner;
      others    = r;
      others[o] = 1'b0;
      if (!r[o]) begin
        m_ptr = (o + 1) % 4;
        w     = first_from(others, (o + 1) % 4);
        if (w >= 0) begin
          m_owner = w;
          m_sel   = w;
          m_cnt   = 1;
        end else begin
          m_owner = -1;
          m_cnt   = 0;
        end
      end else if (others != 4'b0000 && m_cnt == H) begin
        m_ptr   = (o + 1) % 4;
        m_owner = first_from(others, (o + 1) % 4);
        m_sel   = m_owner;
        m_cnt   = 1;
      end else if (m_cnt < H) begin
        m_cnt = m_cnt + 1;
      end
    end
  endtask

  task automatic check_outputs();
    logic [3:0] exp_gnt;
    exp_gnt = 4'b0000;
    if (m_owner >= 0) exp_gnt[m_owner] = 1'b1;
    check("gnt", gnt, exp_gnt);
    check("sel", sel, m_sel);
    check("busy", busy, (m_owner >= 0) ? 1 : 0);
    if (m_owner >= 0) check("mux", mux_out, mux_data[m_owner]);
  endtask

  // drive req, clock once, compare 1 time unit after the edge
  task automatic step(input logic [3:0] r);
    req = r;
    @(posedge clk);
    model_step(r);
    #1;
    check_outputs();
  endtask

  // reset asserted between edges, checked immediately, released at negedge
  task automatic mid_reset();
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("rst_gnt", gnt, 4'b0000);
    check("rst_sel", sel, 2'd0);
    check("rst_busy", busy, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ord[9];
    logic [3:0] r;
    n_checks = 0;
    n_errors = 0;
    mux_data = 4'b0101;  // a=1, b=0, c=1, d=0
    req      = 4'b0000;
    reset_n  = 1'b0;
    model_reset();

    // reset and single request
    repeat (2) @(posedge clk);
    #1;
    check("reset_gnt", gnt, 4'b0000);
    check("reset_sel", sel, 2'd0);
    check("reset_busy", busy, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    step(4'b0100);
    check("single_gnt", gnt, 4'b0100);
    check("single_sel", sel, 2'd2);
    check("single_busy", busy, 1'b1);
    step(4'b0000);
    check("idle_gnt", gnt, 4'b0000);
    check("idle_sel_hold", sel, 2'd2);

    // fair rotation, HOLD_MAX=2
    @(posedge clk);
    mid_reset();
    ord = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    for (int i = 0; i < 9; i++) begin
      step(4'b1111);
      check("rot_sel", sel, ord[i]);
      check("rot_mux", mux_out, mux_data[ord[i]]);
    end

    // release handover with wrap from owner 1
    @(posedge clk);
    mid_reset();
    step(4'b0010);
    step(4'b0011);
    check("own1_sel", sel, 2'd1);
    step(4'b0001);
    check("rel_gnt", gnt, 4'b0001);
    check("rel_sel", sel, 2'd0);
    check("rel_ptr", dut.ptr_q, 2'd2);
    step(4'b0101);
    step(4'b0101);
    check("rel_next_gnt", gnt, 4'b0100);

    // saturation
    @(posedge clk);
    mid_reset();
    for (int i = 0; i < 20; i++) begin
      step(4'b1000);
      check("sat_gnt", gnt, 4'b1000);
      if (i > 0) check("sat_cnt", dut.cnt_q, H);
    end
    step(4'b1001);
    check("sat_move_gnt", gnt, 4'b0001);

    // async reset mid-grant
    @(posedge clk);
    mid_reset();
    step(4'b0010);
    check("pre_rst_gnt", gnt, 4'b0010);
    mid_reset();
    step(4'b1111);
    check("post_rst_gnt", gnt, 4'b0001);

    // randomized traffic against the model
    r = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 1) == 0) r = 4'($urandom_range(0, 15));
      step(r);
      if ($urandom_range(0, 79) == 0) mid_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
